// File: rtl/xcore_gnrl_fifo_dp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : xcore_gnrl_fifo_dp_pkg
// Purpose  : Shared definitions for the general FIFO family.
//            - Pointer width rule: an index plus one wrap bit.
//            - Wrapping pointer increment helper.
//            - Encoding of the per-cycle push/pop operation.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package xcore_gnrl_fifo_dp_pkg;

   // Number of extra bits carried above the RAM index to tell full from empty.
   localparam int unsigned PTR_WRAP_BITS = 1;

   // Widest pointer the increment helper can handle.
   localparam int unsigned PTR_MAX_W = 32;

   // Per-cycle operation, encoded as {push, pop}.
   typedef enum logic [1:0] {
      OP_IDLE = 2'b00,
      OP_POP  = 2'b01,
      OP_PUSH = 2'b10,
      OP_BOTH = 2'b11
   } fifo_op_t;

   // Pointer width for a RAM address width of aw bits.
   function automatic int unsigned ptr_width(input int unsigned aw);
      return aw + PTR_WRAP_BITS;
   endfunction

   // Increment a pointer of (aw + wrap) bits, modulo 2^(aw + wrap). The wrap
   // bit toggles naturally when the index rolls over from its maximum.
   function automatic logic [PTR_MAX_W-1:0] ptr_inc(
      input logic [PTR_MAX_W-1:0] ptr,
      input int unsigned          aw
   );
      logic [PTR_MAX_W-1:0] mask;
      mask = (PTR_MAX_W'(1) << (aw + PTR_WRAP_BITS)) - PTR_MAX_W'(1);
      return (ptr + PTR_MAX_W'(1)) & mask;
   endfunction

endpackage
`default_nettype wire

// File: rtl/Xcore_gnrl_ramdp_nr.sv
`default_nettype none
// ============================================================================
// Module   : Xcore_gnrl_ramdp_nr
// Purpose  : General dual-port RAM without reset. One synchronous write port,
//            one combinational read port.
// Ports    : clk    - clock
//            cs     - chip select (gates writes; gates read data when
//                     FORCE_ZERO=1)
//            we     - write enable
//            waddr  - write address
//            wdat   - write data
//            raddr  - read address
//            rdat   - read data (combinational)
// Params   : DL depth, DW data width, AW address width,
//            FORCE_ZERO drive rdat to zero while cs=0 (simulation aid)
// Revision : 1.0 - initial release
// ============================================================================
module Xcore_gnrl_ramdp_nr #(
   parameter int DL         = 4,
   parameter int DW         = 32,
   parameter int AW         = 2,
   parameter bit FORCE_ZERO = 1'b0
) (
   input  logic          clk,
   input  logic          cs,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdat,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdat
);

   // Storage is intentionally never reset.
   logic [DW-1:0] mem [DL];

   always_ff @(posedge clk) begin
      if (cs && we) begin
         mem[waddr] <= wdat;
      end
   end

   generate
      if (FORCE_ZERO) begin : g_force_zero
         assign rdat = cs ? mem[raddr] : '0;
      end else begin : g_plain_read
         assign rdat = mem[raddr];
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/xcore_gnrl_fifo_dp.sv
`default_nettype none
// ============================================================================
// Module   : xcore_gnrl_fifo_dp
// Purpose  : Synchronous valid/ready FIFO controller around the general
//            dual-port no-reset RAM. Holds the pointers, decodes full/empty/
//            count and qualifies the handshakes.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            i_vld/i_rdy/i_dat - producer side (i_rdy = ~full)
//            o_vld/o_rdy/o_dat - consumer side (o_vld = ~empty)
//            full, empty     - occupancy flags
//            count           - occupancy, 0..DP
// Params   : DW data width, DP depth (power of two, >= 2), AW = $clog2(DP),
//            FORCE_ZERO passed through to the RAM
// Revision : 1.0 - initial release
// ============================================================================
module xcore_gnrl_fifo_dp
   import xcore_gnrl_fifo_dp_pkg::*;
#(
   parameter int DW         = 32,
   parameter int DP         = 4,
   parameter int AW         = $clog2(DP),
   parameter bit FORCE_ZERO = 1'b0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_vld,
   output logic          i_rdy,
   input  logic [DW-1:0] i_dat,
   output logic          o_vld,
   input  logic          o_rdy,
   output logic [DW-1:0] o_dat,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   count
);

   localparam int unsigned PW = ptr_width(AW);

   logic [PW-1:0] r_wptr;
   logic [PW-1:0] r_rptr;
   logic          w_push;
   logic          w_pop;
   fifo_op_t      w_op;
   logic [PW-1:0] w_wptr_nxt;
   logic [PW-1:0] w_rptr_nxt;

   // Status comes only from the registered pointers, so no output has a
   // combinational path from any input (in particular o_rdy -> i_rdy).
   assign empty = (r_wptr == r_rptr);
   assign full  = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
   assign count = r_wptr - r_rptr;

   assign i_rdy = ~full;
   assign o_vld = ~empty;

   // A full FIFO refuses a push even when a pop happens in the same cycle,
   // and an empty FIFO never bypasses input to output.
   assign w_push = i_vld & i_rdy;
   assign w_pop  = o_vld & o_rdy;
   assign w_op   = fifo_op_t'({w_push, w_pop});

   assign w_wptr_nxt = PW'(ptr_inc(PTR_MAX_W'(r_wptr), AW));
   assign w_rptr_nxt = PW'(ptr_inc(PTR_MAX_W'(r_rptr), AW));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         unique case (w_op)
            OP_PUSH: r_wptr <= w_wptr_nxt;
            OP_POP:  r_rptr <= w_rptr_nxt;
            OP_BOTH: begin
               r_wptr <= w_wptr_nxt;
               r_rptr <= w_rptr_nxt;
            end
            default: ;
         endcase
      end
   end

   // RAM write is gated by the qualified push only, so an offer while full
   // never touches storage.
   Xcore_gnrl_ramdp_nr #(
      .DL         (DP),
      .DW         (DW),
      .AW         (AW),
      .FORCE_ZERO (FORCE_ZERO)
   ) u_ram (
      .clk   (clk),
      .cs    (1'b1),
      .we    (w_push),
      .waddr (r_wptr[AW-1:0]),
      .wdat  (i_dat),
      .raddr (r_rptr[AW-1:0]),
      .rdat  (o_dat)
   );

endmodule
`default_nettype wire

// File: tb/tb_xcore_gnrl_fifo_dp.sv
`default_nettype none
// ============================================================================
// Module   : tb_xcore_gnrl_fifo_dp
// Purpose  : Self-checking bench for xcore_gnrl_fifo_dp (DP=4, DW=8).
//            A queue model of the FIFO is compared against the DUT every
//            cycle; directed sequences add literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_xcore_gnrl_fifo_dp;

   localparam int DW = 8;
   localparam int DP = 4;
   localparam int AW = 2;

   logic          clk;
   logic          rst;
   logic          i_vld;
   logic          i_rdy;
   logic [DW-1:0] i_dat;
   logic          o_vld;
   logic          o_rdy;
   logic [DW-1:0] o_dat;
   logic          full;
   logic          empty;
   logic [AW:0]   count;

   int n_cmp = 0;
   int n_bad = 0;

   xcore_gnrl_fifo_dp #(
      .DW         (DW),
      .DP         (DP),
      .AW         (AW),
      .FORCE_ZERO (1'b1)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .i_vld (i_vld),
      .i_rdy (i_rdy),
      .i_dat (i_dat),
      .o_vld (o_vld),
      .o_rdy (o_rdy),
      .o_dat (o_dat),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [DW-1:0] mq[$];
   bit            model_live = 1'b0;
   int            model_pushes = 0;

   always @(posedge clk) begin
      bit p;
      bit q;
      if (rst) begin
         mq.delete();
         model_live = 1'b1;
      end else if (model_live) begin
         p = i_vld && (mq.size() < DP);
         q = o_rdy && (mq.size() > 0);
         if (q) void'(mq.pop_front());
         if (p) begin
            mq.push_back(i_dat);
            model_pushes++;
         end
      end
   end

   // Compare process: outputs are registered, check them mid-cycle.
   always @(negedge clk) begin
      if (model_live) begin
         chk("model_count", 32'(count), 32'(mq.size()));
         chk("model_empty", 32'(empty), 32'(mq.size() == 0));
         chk("model_full",  32'(full),  32'(mq.size() == DP));
         chk("model_i_rdy", 32'(i_rdy), 32'(mq.size() != DP));
         chk("model_o_vld", 32'(o_vld), 32'(mq.size() != 0));
         if (mq.size() != 0) chk("model_o_dat", 32'(o_dat), 32'(mq[0]));
      end
   end

   // Apply inputs for the coming rising edge, then wait for the next falling
   // edge so that the caller sees the result of that edge.
   task automatic tick(input logic v, input logic [DW-1:0] d, input logic r);
      i_vld = v;
      i_dat = d;
      o_rdy = r;
      @(negedge clk);
   endtask

   // ---------------- directed + random stimulus ----------------
   initial begin
      logic [DW-1:0] fill_vals [4];
      logic [DW-1:0] sent[$];
      logic [DW-1:0] nxt;

      fill_vals[0] = 8'h11;
      fill_vals[1] = 8'h22;
      fill_vals[2] = 8'h33;
      fill_vals[3] = 8'h44;

      rst   = 1'b1;
      i_vld = 1'b0;
      i_dat = '0;
      o_rdy = 1'b0;
      @(negedge clk);

      // Reset with push/pop requests active: reset dominates.
      tick(1'b1, 8'hEE, 1'b1);
      tick(1'b1, 8'hEE, 1'b1);
      rst = 1'b0;
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_o_vld", 32'(o_vld), 32'd0);
      chk("rst_i_rdy", 32'(i_rdy), 32'd1);
      chk("rst_full",  32'(full),  32'd0);
      tick(1'b0, 8'h00, 1'b0);
      chk("idle_count", 32'(count), 32'd0);

      // Fill to full.
      for (int i = 0; i < 4; i++) begin
         tick(1'b1, fill_vals[i], 1'b0);
         chk("fill_count", 32'(count), 32'(i + 1));
      end
      chk("fill_full",  32'(full),  32'd1);
      chk("fill_i_rdy", 32'(i_rdy), 32'd0);
      tick(1'b1, 8'h55, 1'b0);
      chk("overflow_count", 32'(count), 32'd4);

      // Drain in order.
      for (int i = 0; i < 4; i++) begin
         chk("drain_o_dat", 32'(o_dat), 32'(fill_vals[i]));
         tick(1'b0, 8'h00, 1'b1);
      end
      chk("drain_empty", 32'(empty), 32'd1);
      chk("drain_o_vld", 32'(o_vld), 32'd0);
      tick(1'b0, 8'h00, 1'b1);
      chk("underflow_count", 32'(count), 32'd0);
      // A push after the underflow attempt must be the next head.
      tick(1'b1, 8'h66, 1'b0);
      chk("post_uflow_o_dat", 32'(o_dat), 32'h66);
      chk("post_uflow_count", 32'(count), 32'd1);
      tick(1'b0, 8'h00, 1'b1);

      // Simultaneous push/pop at count=2 with wrap.
      tick(1'b1, 8'hA0, 1'b0);
      tick(1'b1, 8'hA1, 1'b0);
      sent.push_back(8'hA0);
      sent.push_back(8'hA1);
      for (int i = 0; i < 10; i++) begin
         nxt = DW'(i + 1);
         chk("pp_o_dat", 32'(o_dat), 32'(sent[0]));
         void'(sent.pop_front());
         sent.push_back(nxt);
         tick(1'b1, nxt, 1'b1);
         chk("pp_count", 32'(count), 32'd2);
      end
      // 4 + 1 + 2 + 10 pushes so far: index has rolled over more than twice.
      chk("pp_wraps", 32'(model_pushes >= 2 * DP + 2), 32'd1);

      // Full boundary: push+pop request while full -> only pop.
      tick(1'b1, 8'hB0, 1'b0);
      tick(1'b1, 8'hB1, 1'b0);
      chk("full_before", 32'(full), 32'd1);
      chk("full_head", 32'(o_dat), 32'h09);
      tick(1'b1, 8'h77, 1'b1);
      chk("fullpp_count", 32'(count), 32'd3);
      chk("fullpp_i_rdy", 32'(i_rdy), 32'd1);
      chk("fullpp_head", 32'(o_dat), 32'h0A);

      // Mid-operation reset at count=3.
      rst = 1'b1;
      tick(1'b0, 8'h00, 1'b0);
      rst = 1'b0;
      chk("mrst_empty", 32'(empty), 32'd1);
      chk("mrst_count", 32'(count), 32'd0);
      tick(1'b1, 8'hA5, 1'b0);
      chk("mrst_o_vld", 32'(o_vld), 32'd1);
      chk("mrst_o_dat", 32'(o_dat), 32'hA5);
      tick(1'b0, 8'h00, 1'b1);

      // Randomized traffic with occasional reset, checked by the model.
      for (int i = 0; i < 600; i++) begin
         rst = ($urandom_range(0, 79) == 0);
         tick(1'($urandom_range(0, 3) != 0), DW'($urandom), 1'($urandom_range(0, 2) != 0));
      end
      rst = 1'b0;
      tick(1'b0, 8'h00, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/xcore_gnrl_fifo_dp.md
# xcore_gnrl_fifo_dp

Synchronous valid/ready FIFO controller that owns both ends of the general dual-port no-reset RAM. It drives the write port from an upstream producer and the read port toward a downstream consumer. It provides full/empty/occupancy status for core-side buffering, such as fetch and LSU queues. Storage is the shared general dual-port RAM; this block supplies all pointer, flag and handshake logic.

## Interface
- DW, 32: data width in bits.
- DP, 4: depth in entries; power of two, at least 2.
- AW, $clog2(DP): RAM address width.
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- i_vld  in  1  producer offers i_dat.
- i_rdy  out  1  FIFO can accept; equals ~full.
- i_dat  in  DW  write data.
- o_vld  out  1  head entry valid; equals ~empty.
- o_rdy  in  1  consumer accepts head.
- o_dat  out  DW  head entry data.
- full  out  1  count == DP.
- empty  out  1  count == 0.
- count  out  AW+1  current occupancy, 0..DP.

## Operation
- Push = i_vld & i_rdy; pop = o_vld & o_rdy; both are evaluated in the same cycle.
- Write pointer wptr and read pointer rptr are each AW+1 bits wide: an AW-bit index plus a wrap bit.
- On push: RAM write at wptr[AW-1:0] with i_dat; wptr increments modulo 2^(AW+1).
- On pop: rptr increments modulo 2^(AW+1).
- RAM chip select is tied to 1. RAM we = push. RAM raddr = rptr[AW-1:0], read combinationally, so o_dat is the head entry.
- Flag equations:
  - empty = (wptr == rptr).
  - full = (index bits equal) & (wrap bits differ).
  - count = wptr - rptr, in AW+1-bit arithmetic.
- Flags and count are derived combinationally from the registered pointers; no extra count register.
- i_rdy does not depend on o_rdy. When full, push is refused even if a pop occurs in the same cycle. No combinational path from o_rdy to i_rdy.
- o_vld does not depend on i_vld. When empty there is no bypass; a pushed word becomes visible the following cycle.
- Boundary conditions:
  - Push and pop in the same cycle when 0 < count < DP: count unchanged, both pointers advance.
  - Push and pop in the same cycle when empty: pop is impossible (o_vld=0), so only the push takes effect.
  - Push and pop in the same cycle when full: push is impossible (i_rdy=0), so only the pop takes effect.
  - Wrap-around: index rolls from DP-1 to 0 and the wrap bit toggles; no data loss across the boundary.
  - i_vld while full: ignored, RAM not written, no overflow.
  - o_rdy while empty: ignored, rptr unchanged, no underflow.
- RAM contents are never reset. o_dat is don't-care while o_vld=0.
- The RAM's FORCE_ZERO option is 0 for synthesis; benches may set it to 1.

## Timing
- Reset: at a clk edge with rst=1, wptr=rptr=0. Resulting outputs:
  - empty=1, full=0, count=0.
  - o_vld=0, i_rdy=1.
  - Takes effect in the cycle after that edge. rst dominates any push or pop in the same cycle.
- Reset mid-operation: all stored entries are discarded logically. RAM is not cleared; stale data is never presented because o_vld=0.
- Push latency: data pushed at edge N appears on o_dat with o_vld=1 in cycle N+1, when the FIFO was empty.
- Pop: the head advances at the accepting edge. The next entry, if any, appears on o_dat in the same following cycle.
- Throughput: one push and one pop per cycle sustained at any non-boundary occupancy.
- All outputs change only after clk edges; there are no outputs that are combinational from inputs.

## Structure
- Shared package: the pointer-width constant (AW+1) and a helper function for pointer increment with wrap bit. Reused by future async or skid FIFOs.
- One sub-module: Xcore_gnrl_ramdp_nr, instantiated as the storage array with DL=DP, DW=DW, AW=AW.
- All control logic stays in this module: pointer registers, flag and count decode, and handshake qualification.

## Test plan
- Reset and idle:
  - Stimulus: assert rst for 2 cycles with i_vld=1 and o_rdy=1.
  - Required response: after release, count=0, empty=1, o_vld=0, i_rdy=1; no write has taken effect.
- Fill to full (DP=4, DW=8):
  - Stimulus: push 0x11, 0x22, 0x33, 0x44 on consecutive cycles with o_rdy=0.
  - Required response: count steps 1, 2, 3, 4, then full=1 and i_rdy=0.
  - Follow-up: a 5th push of 0x55 is refused and count stays 4.
- Drain in order:
  - Stimulus: from full, hold o_rdy=1.
  - Required response: o_dat reads 0x11, 0x22, 0x33, 0x44 in consecutive cycles, then empty=1 and o_vld=0.
  - Follow-up: a further o_rdy=1 leaves rptr unchanged.
- Simultaneous push/pop and wrap:
  - Stimulus: at count=2, push and pop together for 10 cycles with incrementing data.
  - Required response: count stays 2, output order equals input order, and the pointers wrap at least twice.
- Full-boundary simultaneous events:
  - Stimulus: at count=4, i_vld=1 and o_rdy=1 in the same cycle.
  - Required response: only the pop occurs and count becomes 3; next cycle i_rdy=1.
- Mid-operation reset:
  - Stimulus: at count=3, pulse rst for 1 cycle.
  - Required response: the next cycle shows empty=1 and count=0; a new push of 0xA5 then appears on o_dat one cycle later.
